// File: rtl/adder_defs.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default width.
package adder_defs;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the per-bit engine of the serial adder.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_p;

    assign w_p  = A ^ B;
    assign sum  = w_p ^ cin;
    assign cout = (A & B) | (cin & w_p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit pair per clock, LSB first, result after WIDTH edges.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
    import adder_defs::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             w_s;
    logic             w_co;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    full_adder u_full_adder (
        .A    (r_a[0]),
        .B    (r_b[0]),
        .cin  (r_carry),
        .sum  (w_s),
        .cout (w_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = (r_cnt == LAST_BIT);
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                // Back-to-back: a start seen during DONE goes straight to RUN.
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_co;
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_co;
`ifdef SERIAL_ADDER_OVF_EN
                // r_carry is the carry into the MSB on the final bit.
                r_ovf  <= r_carry ^ w_co;
`endif
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table, scoreboard and corner sequences.
module tb_serial_adder;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         c_in;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         done;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    vec_t vecs[6];

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .cin   (c_in),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive a start request (call away from the rising edge); returns just after the accept edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] full;
        exp_t       e;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.s    = full[W-1:0];
        e.co   = full[W];
        e.ov   = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        sb.push_back(e);
        a_in   = a;
        b_in   = b;
        c_in   = c;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    // Wait (bounded) for done, counting busy cycles, then pop and compare the scoreboard.
    task automatic collect(input string name, output int nbusy);
        bit   seen;
        exp_t e;
        nbusy = 0;
        seen  = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
            else if (busy) nbusy++;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            check({name, "_sum"}, 32'(sum), 32'(e.s));
            check({name, "_cout"}, 32'(cout), 32'(e.co));
`ifdef SERIAL_ADDER_OVF_EN
            check({name, "_ovf"}, 32'(ovf), 32'(e.ov));
`endif
            check({name, "_busy_during_done"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int   nb;
        int   ndone;
        exp_t dummy;

        vecs[0] = '{a: 8'h00, b: 8'h00, c: 1'b0, s: 8'h00, co: 1'b0, ov: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, c: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b0};
        vecs[2] = '{a: 8'h7F, b: 8'h01, c: 1'b0, s: 8'h80, co: 1'b0, ov: 1'b1};
        vecs[3] = '{a: 8'h80, b: 8'h80, c: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b1};
        vecs[4] = '{a: 8'hFF, b: 8'hFF, c: 1'b1, s: 8'hFF, co: 1'b1, ov: 1'b0};
        vecs[5] = '{a: 8'h3C, b: 8'h0F, c: 1'b1, s: 8'h4C, co: 1'b0, ov: 1'b0};

        rst   = 1'b1;
        start = 1'b1;
        a_in  = 8'hAA;
        b_in  = 8'h55;
        c_in  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        // Table vectors, each from IDLE.
        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].c);
            // Table record and scoreboard model must agree.
            dummy = sb[sb.size() - 1];
            check($sformatf("vec%0d_model", i), {23'd0, dummy.s, dummy.co},
                  {23'd0, vecs[i].s, vecs[i].co});
            collect($sformatf("vec%0d", i), nb);
            check($sformatf("vec%0d_busy_cycles", i), 32'(nb), 32'(W));
            @(negedge clk);
            check($sformatf("vec%0d_done_single", i), 32'(done), 32'd0);
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_hold_sum", i), 32'(sum), 32'(vecs[i].s));
            check($sformatf("vec%0d_hold_cout", i), 32'(cout), 32'(vecs[i].co));
        end

        // Back-to-back: start during DONE re-enters RUN with no dead cycle.
        launch(8'hA5, 8'h5A, 1'b1);
        collect("b2b_first", nb);
        launch(8'h03, 8'h04, 1'b0);
        @(negedge clk);
        check("b2b_busy_immediate", 32'(busy), 32'd1);
        collect("b2b_second", nb);
        check("b2b_latency", 32'(nb + 1), 32'(W));
        @(negedge clk);

        // start during RUN is ignored.
        launch(8'h12, 8'h34, 1'b0);
        repeat (3) @(negedge clk);
        a_in  = 8'hFF;
        b_in  = 8'hFF;
        c_in  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        collect("run_restart", nb);
        @(negedge clk);

        // Reset mid-operation aborts with no done pulse.
        launch(8'h55, 8'h22, 1'b0);
        dummy = sb.pop_back();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        launch(8'h10, 8'h20, 1'b1);
        collect("after_abort", nb);
        check("after_abort_busy_cycles", 32'(nb), 32'(W));
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
